// File: rtl/armleocpu_tlb_pkg.sv
// Shared constants and types for the N-way TLB: widths, access-tag bit map,
// and the flush FSM state encoding.
package armleocpu_tlb_pkg;

  localparam int VIRT_W     = 20;
  localparam int PHYS_W_DEF = 22;

  // Access-tag bit positions
  localparam int AT_V = 0;
  localparam int AT_R = 1;
  localparam int AT_W = 2;
  localparam int AT_X = 3;
  localparam int AT_U = 4;
  localparam int AT_G = 5;
  localparam int AT_A = 6;
  localparam int AT_D = 7;

  localparam logic [7:0] DISABLED_ACCESSTAG = 8'b1101_1111;

  typedef enum logic {IDLE, FLUSH} state_t;

endpackage

// File: rtl/armleocpu_tlb_way.sv
// One TLB way: ENTRIES sets of {valid, tag, accesstag[7:1], phys}.
// Async lookup and probe read ports, one write port, one clear-valid port.
module armleocpu_tlb_way #(
  parameter  int ENTRIES = 16,
  parameter  int TAG_W   = 16,
  parameter  int PHYS_W  = 22,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  // lookup port (registered resolve address)
  input  logic [IDX_W-1:0]  lk_idx_i,
  input  logic [TAG_W-1:0]  lk_tag_i,
  output logic              lk_hit_o,
  output logic [6:0]        lk_atag_o,
  output logic [PHYS_W-1:0] lk_phys_o,
  // probe port (live address, used by write / invalidate_one)
  input  logic [IDX_W-1:0]  pr_idx_i,
  input  logic [TAG_W-1:0]  pr_tag_i,
  output logic              pr_valid_o,
  output logic              pr_hit_o,
  // write port, addressed by the probe port
  input  logic              we_i,
  input  logic              wr_valid_i,
  input  logic [6:0]        wr_atag_i,
  input  logic [PHYS_W-1:0] wr_phys_i,
  // clear-valid port
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  clr_idx_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [6:0]         atag_q [ENTRIES];
  logic [PHYS_W-1:0]  phys_q [ENTRIES];

  assign lk_hit_o   = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign lk_atag_o  = atag_q[lk_idx_i];
  assign lk_phys_o  = phys_q[lk_idx_i];
  assign pr_valid_o = valid_q[pr_idx_i];
  assign pr_hit_o   = valid_q[pr_idx_i] && (tag_q[pr_idx_i] == pr_tag_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q[clr_idx_i] <= 1'b0;
      if (we_i)  valid_q[pr_idx_i]  <= wr_valid_i;
    end
  end

  // Payload is never reset; valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[pr_idx_i]  <= pr_tag_i;
      atag_q[pr_idx_i] <= wr_atag_i;
      phys_q[pr_idx_i] <= wr_phys_i;
    end
  end

endmodule

// File: rtl/armleocpu_tlb_nway.sv
// N-way set-associative TLB: 1-cycle lookup, round-robin refill,
// single-entry invalidate and a one-set-per-cycle flush sweep.
module armleocpu_tlb_nway
  import armleocpu_tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int WAYS    = 2,
  parameter int PHYS_W  = PHYS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [VIRT_W-1:0] virtual_address,
  input  logic              resolve,
  input  logic              write,
  input  logic              invalidate_one,
  input  logic              invalidate,
  input  logic [7:0]        accesstag_w,
  input  logic [PHYS_W-1:0] phys_w,
  output logic              busy,
  output logic              done,
  output logic              miss,
  output logic [7:0]        accesstag_r,
  output logic [PHYS_W-1:0] phys_r
);

  localparam int ENTRIES_W = $clog2(ENTRIES);
  localparam int TAG_W     = VIRT_W - ENTRIES_W;
  localparam int PTR_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [ENTRIES_W-1:0] va_idx;
  logic [TAG_W-1:0]     va_tag;
  assign va_idx = virtual_address[ENTRIES_W-1:0];
  assign va_tag = virtual_address[VIRT_W-1:ENTRIES_W];

  state_t               state_q, state_d;
  logic [ENTRIES_W-1:0] cnt_q, cnt_d;
  logic                 access_q, enable_q;
  logic [ENTRIES_W-1:0] set_index_q;
  logic [TAG_W-1:0]     virt_tag_q;
  logic [VIRT_W-1:0]    vaddr_q;
  logic [PTR_W-1:0]     rr_q [ENTRIES];

  logic idle, flush_clr;
  logic do_resolve, do_write, do_inv1, do_flush;

  assign idle       = (state_q == IDLE);
  assign busy       = (state_q == FLUSH);
  assign do_resolve = idle & resolve;
  assign do_write   = idle & write & ~resolve;
  assign do_inv1    = idle & invalidate_one & ~resolve & ~write;
  assign do_flush   = idle & invalidate & ~resolve & ~write & ~invalidate_one;

  logic [WAYS-1:0]             lk_hit, pr_valid, pr_hit, wsel;
  logic [WAYS-1:0][6:0]        lk_atag;
  logic [WAYS-1:0][PHYS_W-1:0] lk_phys;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    armleocpu_tlb_way #(
      .ENTRIES (ENTRIES),
      .TAG_W   (TAG_W),
      .PHYS_W  (PHYS_W)
    ) u_way (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_idx_i   (set_index_q),
      .lk_tag_i   (virt_tag_q),
      .lk_hit_o   (lk_hit[w]),
      .lk_atag_o  (lk_atag[w]),
      .lk_phys_o  (lk_phys[w]),
      .pr_idx_i   (va_idx),
      .pr_tag_i   (va_tag),
      .pr_valid_o (pr_valid[w]),
      .pr_hit_o   (pr_hit[w]),
      .we_i       (do_write & wsel[w]),
      .wr_valid_i (accesstag_w[AT_V]),
      .wr_atag_i  (accesstag_w[7:1]),
      .wr_phys_i  (phys_w),
      .clr_i      (flush_clr | (do_inv1 & pr_hit[w])),
      .clr_idx_i  (flush_clr ? cnt_q : va_idx)
    );
  end

  // Victim: matching way, else lowest invalid way, else round-robin pointer.
  logic use_rr, found;
  always_comb begin
    wsel   = '0;
    use_rr = 1'b0;
    found  = 1'b0;
    if (|pr_hit) begin
      for (int w = 0; w < WAYS; w++)
        if (pr_hit[w] && !found) begin
          wsel[w] = 1'b1;
          found   = 1'b1;
        end
    end else if (!(&pr_valid)) begin
      for (int w = 0; w < WAYS; w++)
        if (!pr_valid[w] && !found) begin
          wsel[w] = 1'b1;
          found   = 1'b1;
        end
    end else begin
      use_rr = 1'b1;
      for (int w = 0; w < WAYS; w++)
        wsel[w] = (rr_q[va_idx] == PTR_W'(w));
    end
  end

  logic [PTR_W-1:0] rr_next;
  assign rr_next = (WAYS == 1) ? '0 : rr_q[va_idx] + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) rr_q[i] <= '0;
    end else if (do_write && use_rr) begin
      rr_q[va_idx] <= rr_next;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (do_flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        flush_clr = 1'b1;
        cnt_d     = cnt_q + ENTRIES_W'(1);
        if (cnt_q == ENTRIES_W'(ENTRIES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      access_q    <= 1'b0;
      enable_q    <= 1'b0;
      set_index_q <= '0;
      virt_tag_q  <= '0;
      vaddr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      access_q <= do_resolve;
      if (do_resolve) begin
        enable_q    <= enable;
        set_index_q <= va_idx;
        virt_tag_q  <= va_tag;
        vaddr_q     <= virtual_address;
      end
    end
  end

  // At most one way hits, so an OR across ways is the hit mux.
  logic [PHYS_W-1:0] hit_phys;
  logic [6:0]        hit_atag;
  always_comb begin
    hit_phys = '0;
    hit_atag = '0;
    for (int w = 0; w < WAYS; w++)
      if (lk_hit[w]) begin
        hit_phys = hit_phys | lk_phys[w];
        hit_atag = hit_atag | lk_atag[w];
      end
  end

  assign done        = access_q;
  assign miss        = access_q & enable_q & ~(|lk_hit);
  assign phys_r      = enable_q ? hit_phys : PHYS_W'(vaddr_q);
  assign accesstag_r = enable_q ? {hit_atag, 1'b1} : DISABLED_ACCESSTAG;

endmodule
